// File: rtl/contador_pontos_pkg.sv
// Shared definitions for the score counter: FSM state encoding and BCD digit constants.
package contador_pontos_pkg;

    typedef enum logic {
        JOGANDO = 1'b0,
        VENCEU  = 1'b1
    } estado_t;

    localparam int               DIGITO_W   = 4;
    localparam logic [DIGITO_W-1:0] DIGITO_MAX = 4'd9;

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: two flops preset to 1 so a level held through reset release never counts.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic pulso
);

    logic s1;
    logic s2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= entrada;
            s2 <= s1;
        end
    end

    assign pulso = s1 & ~s2;

endmodule

// File: rtl/contador_pontos.sv
// Two-digit BCD score counter with periodic extra-life pulse and latched victory at META.
// Hit edge sampled at edge k updates score/pulses at edge k+1; held, paused or cleared hits are dropped.
module contador_pontos
    import contador_pontos_pkg::*;
#(
    parameter int BONUS_INTERVALO = 10,
    parameter int META            = 99
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                limpar,
    input  logic                acerto,
    input  logic                pausa,
    output logic [DIGITO_W-1:0] pontos_dez,
    output logic [DIGITO_W-1:0] pontos_uni,
    output logic                vida_extra,
    output logic                vitoria
);

    if (BONUS_INTERVALO < 1 || BONUS_INTERVALO > 99) begin : g_erro_bonus
        $error("BONUS_INTERVALO must be in 1..99");
    end
    if (META < 1 || META > 99) begin : g_erro_meta
        $error("META must be in 1..99");
    end

    localparam logic [6:0]          BONUS_LIM = 7'(BONUS_INTERVALO);
    localparam logic [DIGITO_W-1:0] META_DEZ  = DIGITO_W'(META / 10);
    localparam logic [DIGITO_W-1:0] META_UNI  = DIGITO_W'(META % 10);

    estado_t             estado;
    logic [6:0]          bonus;
    logic [6:0]          bonus_novo;
    logic [DIGITO_W-1:0] dez_novo;
    logic [DIGITO_W-1:0] uni_novo;
    logic                p;
    logic                v;

    detector_borda u_borda (
        .clock   (clock),
        .reset   (reset),
        .entrada (acerto),
        .pulso   (p)
    );

    assign v = p & ~pausa & (estado == JOGANDO) & ~limpar;

    // Score is capped at META <= 99, so the tens digit never needs to wrap.
    always_comb begin
        uni_novo   = pontos_uni + 4'd1;
        dez_novo   = pontos_dez;
        bonus_novo = bonus + 7'd1;
        if (pontos_uni == DIGITO_MAX) begin
            uni_novo = '0;
            dez_novo = pontos_dez + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= JOGANDO;
            pontos_dez <= '0;
            pontos_uni <= '0;
            bonus      <= '0;
            vida_extra <= 1'b0;
            vitoria    <= 1'b0;
        end else if (limpar) begin
            estado     <= JOGANDO;
            pontos_dez <= '0;
            pontos_uni <= '0;
            bonus      <= '0;
            vida_extra <= 1'b0;
            vitoria    <= 1'b0;
        end else begin
            vida_extra <= 1'b0;
            case (estado)
                JOGANDO: begin
                    if (v) begin
                        pontos_dez <= dez_novo;
                        pontos_uni <= uni_novo;
                        if (bonus_novo == BONUS_LIM) begin
                            bonus      <= '0;
                            vida_extra <= 1'b1;
                        end else begin
                            bonus <= bonus_novo;
                        end
                        if (dez_novo == META_DEZ && uni_novo == META_UNI) begin
                            estado  <= VENCEU;
                            vitoria <= 1'b1;
                        end
                    end
                end
                VENCEU: begin
                    vitoria <= 1'b1;
                end
                default: begin
                    estado <= JOGANDO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_contador_pontos.sv
// Bench: two instances (default and META=12/BONUS=12) sharing stimulus, checked by table and integer-score model.
module tb_contador_pontos;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       limpar = 1'b0;
    logic       acerto = 1'b0;
    logic       pausa  = 1'b0;
    logic [3:0] d0_dez, d0_uni, d1_dez, d1_uni;
    logic       d0_ve, d0_vit, d1_ve, d1_vit;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    contador_pontos u_d0 (
        .clock(clock), .reset(reset), .limpar(limpar), .acerto(acerto), .pausa(pausa),
        .pontos_dez(d0_dez), .pontos_uni(d0_uni), .vida_extra(d0_ve), .vitoria(d0_vit)
    );

    contador_pontos #(.BONUS_INTERVALO(12), .META(12)) u_d1 (
        .clock(clock), .reset(reset), .limpar(limpar), .acerto(acerto), .pausa(pausa),
        .pontos_dez(d1_dez), .pontos_uni(d1_uni), .vida_extra(d1_ve), .vitoria(d1_vit)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    endtask

    // Reference model: integer score, hit counted when acerto rose one edge earlier.
    typedef struct {
        int score;
        int bonus;
        bit won;
        bit ve;
    } mstate_t;

    mstate_t m0, m1;
    bit      h1, h2;

    function automatic mstate_t prox(mstate_t s, bit hit, bit clr, int bi, int mt);
        mstate_t n = s;
        if (clr) begin
            n.score = 0; n.bonus = 0; n.won = 0; n.ve = 0;
        end else begin
            n.ve = 0;
            if (hit && !s.won) begin
                n.score = s.score + 1;
                n.bonus = s.bonus + 1;
                if (n.bonus == bi) begin
                    n.bonus = 0;
                    n.ve    = 1;
                end
                if (n.score == mt) n.won = 1;
            end
        end
        return n;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            h1 <= 1'b1;
            h2 <= 1'b1;
            m0 <= '{0, 0, 1'b0, 1'b0};
            m1 <= '{0, 0, 1'b0, 1'b0};
        end else begin
            m0 <= prox(m0, h1 && !h2 && !pausa, limpar, 10, 99);
            m1 <= prox(m1, h1 && !h2 && !pausa, limpar, 12, 12);
            h1 <= acerto;
            h2 <= h1;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("mdl_d0_dez", int'(d0_dez), m0.score / 10);
            chk("mdl_d0_uni", int'(d0_uni), m0.score % 10);
            chk("mdl_d0_ve",  int'(d0_ve),  int'(m0.ve));
            chk("mdl_d0_vit", int'(d0_vit), int'(m0.won));
            chk("mdl_d1_dez", int'(d1_dez), m1.score / 10);
            chk("mdl_d1_uni", int'(d1_uni), m1.score % 10);
            chk("mdl_d1_ve",  int'(d1_ve),  int'(m1.ve));
            chk("mdl_d1_vit", int'(d1_vit), int'(m1.won));
        end
    end

    typedef struct {
        bit a;
        bit l;
        int dez0, uni0;
        bit ve0;
        int dez1, uni1;
        bit ve1, vit1;
    } vec_t;

    // c = hits counted so far, f = a hit landed on this edge.
    function automatic vec_t mk(bit a, bit l, int c, bit f);
        vec_t r;
        int   c1;
        c1     = (c > 12) ? 12 : c;
        r.a    = a;
        r.l    = l;
        r.dez0 = c / 10;
        r.uni0 = c % 10;
        r.ve0  = f && (c % 10 == 0) && (c != 0);
        r.dez1 = c1 / 10;
        r.uni1 = c1 % 10;
        r.ve1  = f && (c == 12);
        r.vit1 = (c >= 12);
        return r;
    endfunction

    task automatic step(input bit a, input bit p, input bit l);
        @(negedge clock);
        acerto = a;
        pausa  = p;
        limpar = l;
        @(posedge clock);
        #1;
    endtask

    task automatic pulsos(input int n);
        repeat (n) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    vec_t tab[43];

    initial begin
        tab[0] = mk(1'b1, 1'b0, 0, 1'b0);
        tab[1] = mk(1'b0, 1'b0, 0, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            tab[2*n]   = mk(1'b1, 1'b0, n - 1, 1'b0);
            tab[2*n+1] = mk(1'b0, 1'b0, n, 1'b1);
        end
        tab[42] = mk(1'b0, 1'b1, 0, 1'b0);

        // Reset held with acerto high.
        acerto = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_d0_dez", int'(d0_dez), 0);
        chk("rst_d0_uni", int'(d0_uni), 0);
        chk("rst_d0_ve",  int'(d0_ve),  0);
        chk("rst_d0_vit", int'(d0_vit), 0);
        chk("rst_d1_vit", int'(d1_vit), 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 43; i++) begin
            step(tab[i].a, 1'b0, tab[i].l);
            chk($sformatf("tab%0d_d0_dez", i), int'(d0_dez), tab[i].dez0);
            chk($sformatf("tab%0d_d0_uni", i), int'(d0_uni), tab[i].uni0);
            chk($sformatf("tab%0d_d0_ve", i),  int'(d0_ve),  int'(tab[i].ve0));
            chk($sformatf("tab%0d_d1_dez", i), int'(d1_dez), tab[i].dez1);
            chk($sformatf("tab%0d_d1_uni", i), int'(d1_uni), tab[i].uni1);
            chk($sformatf("tab%0d_d1_ve", i),  int'(d1_ve),  int'(tab[i].ve1));
            chk($sformatf("tab%0d_d1_vit", i), int'(d1_vit), int'(tab[i].vit1));
        end

        // Pausa: three pulses dropped, release while acerto still held.
        repeat (3) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("pausa_hold_uni", int'(d0_uni), 0);
        pulsos(1);
        chk("pausa_next_uni", int'(d0_uni), 1);

        // limpar coincident with a hit at score 07.
        pulsos(6);
        chk("pre_clr_uni", int'(d0_uni), 7);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("clr_hit_dez", int'(d0_dez), 0);
        chk("clr_hit_uni", int'(d0_uni), 0);
        pulsos(9);
        chk("clr_9_uni", int'(d0_uni), 9);
        chk("clr_9_ve",  int'(d0_ve),  0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("clr_10_dez", int'(d0_dez), 1);
        chk("clr_10_ve",  int'(d0_ve),  1);
        step(1'b0, 1'b0, 1'b0);
        chk("clr_10_ve_drop", int'(d0_ve), 0);

        // Asynchronous reset mid-cycle at 37 with a hit pending.
        pulsos(27);
        chk("pre_rst_dez", int'(d0_dez), 3);
        chk("pre_rst_uni", int'(d0_uni), 7);
        chk("pre_rst_vit1", int'(d1_vit), 1);
        step(1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_d0_dez", int'(d0_dez), 0);
        chk("arst_d0_uni", int'(d0_uni), 0);
        chk("arst_d0_ve",  int'(d0_ve),  0);
        chk("arst_d1_vit", int'(d1_vit), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(i < 2, 1'b0, 1'b0);
            chk($sformatf("post_rst%0d_uni", i), int'(d0_uni), 0);
            chk($sformatf("post_rst%0d_ve", i),  int'(d0_ve),  0);
        end

        // Random traffic against the model.
        repeat (3000) begin
            @(negedge clock);
            acerto = 1'($urandom_range(0, 1));
            pausa  = ($urandom_range(0, 3) == 0);
            limpar = ($urandom_range(0, 999) == 0);
        end

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
